// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-requester beat counters are enabled with the FIFO_ARB_STATS_EN macro.

package fifo_pkg;
  localparam int DATA_WIDTH = 16;
endpackage

module fifo_wr_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  BURST_LEN  = 4,
  localparam int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  localparam int IDW        = $clog2(NUM_REQ),
  localparam int CW         = $clog2(BURST_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic                          gnt_active,
  output logic [IDW-1:0]                gnt_id
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_REQ*16-1:0]         stat_gnt_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0]  sel;
  logic            found;
  int              idx;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    return (i == IDW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // In IDLE search from rr_ptr upward; with nothing valid, sel parks on rr_ptr.
  always_comb begin
    sel   = rr_ptr_q;
    found = 1'b0;
    idx   = 0;
    if (state_q == LOCK) begin
      sel = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && req_valid[idx]) begin
          sel   = IDW'(idx);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    fifo_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDW'(i)) fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && !fifo_full) req_ready[sel] = 1'b1;
  end

  assign fifo_wr_en = rst_n && !fifo_full && req_valid[sel];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (fifo_wr_en) begin
          if (BURST_LEN > 1) begin
            state_d    = LOCK;
            owner_d    = sel;
            beat_cnt_d = CW'(1);
          end else begin
            rr_ptr_d = wrap_inc(sel);
          end
        end
      end
      LOCK: begin
        // An owner dropping valid releases the lock even while the FIFO is full.
        if (!req_valid[owner_q] ||
            (fifo_wr_en && (beat_cnt_q + 1'b1) == CW'(BURST_LEN))) begin
          state_d    = IDLE;
          rr_ptr_d   = wrap_inc(owner_q);
          beat_cnt_d = '0;
        end else if (fifo_wr_en) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign gnt_active = (state_q == LOCK);
  assign gnt_id     = owner_q;

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [15:0] cnt_q, cnt_d;

    // Clear wins over a coinciding beat; counts saturate at all-ones.
    always_comb begin
      cnt_d = cnt_q;
      if (stat_clr) begin
        cnt_d = '0;
      end else if (fifo_wr_en && sel == IDW'(g) && cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign stat_gnt_cnt[g*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a BURST_LEN=1 instance and a BURST_LEN=4 instance share stimulus.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic              fifo_full;

  logic [NR-1:0] ready1, ready4;
  logic          wr_en1, wr_en4;
  logic [DW-1:0] wr_data1, wr_data4;
  logic          ga1, ga4;
  logic [1:0]    gid1, gid4;
`ifdef FIFO_ARB_STATS_EN
  logic             stat_clr;
  logic [NR*16-1:0] stat1, stat4;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready1), .fifo_wr_en(wr_en1), .fifo_wr_data(wr_data1),
    .fifo_full(fifo_full), .gnt_active(ga1), .gnt_id(gid1)
`ifdef FIFO_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_gnt_cnt(stat1)
`endif
  );

  fifo_wr_arbiter #(.NUM_REQ(NR), .BURST_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready4), .fifo_wr_en(wr_en4), .fifo_wr_data(wr_data4),
    .fifo_full(fifo_full), .gnt_active(ga4), .gnt_id(gid4)
`ifdef FIFO_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_gnt_cnt(stat4)
`endif
  );

  typedef struct packed {
    logic [15:0] data;
    logic        ga;
    logic [1:0]  gid;
    logic [1:0]  src;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  bit   en1 = 1'b0;
  bit   en4 = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push1(input logic [15:0] d, input logic ga, input logic [1:0] gid, input logic [1:0] src);
    exp_t e;
    e = '{data: d, ga: ga, gid: gid, src: src};
    q1.push_back(e);
  endtask

  task automatic push4(input logic [15:0] d, input logic ga, input logic [1:0] gid, input logic [1:0] src);
    exp_t e;
    e = '{data: d, ga: ga, gid: gid, src: src};
    q4.push_back(e);
  endtask

  always @(negedge clk) begin
    if (en1 && wr_en1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_unexpected_beat actual=%0h required=none", wr_data1);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_wr_data", wr_data1, e1.data);
        chk("dut1_gnt_active", ga1, e1.ga);
        chk("dut1_gnt_id", gid1, e1.gid);
        chk("dut1_req_ready", ready1, 4'b0001 << e1.src);
      end
    end
    if (en4 && wr_en4) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut4_unexpected_beat actual=%0h required=none", wr_data4);
      end else begin
        e4 = q4.pop_front();
        chk("dut4_wr_data", wr_data4, e4.data);
        chk("dut4_gnt_active", ga4, e4.ga);
        chk("dut4_gnt_id", gid4, e4.gid);
        chk("dut4_req_ready", ready4, 4'b0001 << e4.src);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 16'hA000 + 16'(i);
    rst_n     = 1'b1;
    req_valid = '1;
    fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    #2 rst_n = 1'b0;
    tick();
    chk("rst_wr_en1", wr_en1, 0);
    chk("rst_wr_en4", wr_en4, 0);
    chk("rst_ready1", ready1, 0);
    chk("rst_ready4", ready4, 0);
    chk("rst_gnt_active", ga4, 0);
    chk("rst_gnt_id", gid4, 0);

    // Per-beat round robin on the BURST_LEN=1 instance.
    push1(16'hA000, 0, 0, 0);
    push1(16'hA001, 0, 0, 1);
    push1(16'hA002, 0, 0, 2);
    push1(16'hA003, 0, 0, 3);
    push1(16'hA000, 0, 0, 0);
    en1   = 1'b1;
    rst_n = 1'b1;
    repeat (5) tick();
    req_valid = '0;
    en1 = 1'b0;
    #1 chk("idle_no_req_wr_en", wr_en1, 0);

    // Burst lock: requesters 1 and 3 alternate in bursts of four.
    do_reset();
    en4 = 1'b1;
    push4(16'hA001, 0, 0, 1);
    repeat (3) push4(16'hA001, 1, 1, 1);
    push4(16'hA003, 0, 1, 3);
    repeat (3) push4(16'hA003, 1, 3, 3);
    push4(16'hA001, 0, 3, 1);
    req_valid = 4'b1010;
    repeat (9) tick();
    req_valid = '0;
    tick();
    chk("burst_released", ga4, 0);

    // Reset asserted mid-LOCK (owner 2, two beats done).
    do_reset();
    push4(16'hA002, 0, 0, 2);
    push4(16'hA002, 1, 2, 2);
    req_valid = 4'b0100;
    tick();
    tick();
    chk("prerst_gnt_active", ga4, 1);
    chk("prerst_gnt_id", gid4, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", wr_en4, 0);
    chk("midrst_ready", ready4, 0);
    chk("midrst_gnt_active", ga4, 0);
    chk("midrst_gnt_id", gid4, 0);
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("postrst_gnt_active", ga4, 0);
    chk("postrst_gnt_id", gid4, 0);
    push4(16'hA000, 0, 0, 0);
    tick();
    req_valid = '0;
    tick();
    tick();

    // Full stall while locked to requester 0 after one beat.
    do_reset();
    push4(16'hA000, 0, 0, 0);
    req_valid = 4'b0001;
    tick();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("full_wr_en", wr_en4, 0);
      chk("full_ready", ready4, 0);
      chk("full_gnt_active", ga4, 1);
      tick();
    end
    fifo_full = 1'b0;
    repeat (3) push4(16'hA000, 1, 0, 0);
    repeat (3) tick();
    chk("full_release_after_3", ga4, 0);
    req_valid = '0;
    tick();

    // Early release: owner 2 drops valid after two beats, requester 0 waiting.
    do_reset();
    push4(16'hA002, 0, 0, 2);
    req_valid = 4'b0100;
    tick();
    push4(16'hA002, 1, 2, 2);
    req_valid = 4'b0101;
    tick();
    req_valid = 4'b0001;
    #1;
    chk("early_no_beat", wr_en4, 0);
    chk("early_still_locked", ga4, 1);
    tick();
    chk("early_idle", ga4, 0);
    chk("early_gnt_id_held", gid4, 2);
    push4(16'hA000, 0, 2, 0);
    tick();
    req_valid = '0;
    tick();
    en4 = 1'b0;

    chk("q1_drained", q1.size(), 0);
    chk("q4_drained", q4.size(), 0);

`ifdef FIFO_ARB_STATS_EN
    do_reset();
    req_valid = 4'b0001;
    repeat (70000) tick();
    req_valid = '0;
    tick();
    chk("stat_req0_sat", stat4[15:0], 16'hFFFF);
    chk("stat_others_zero", stat4[NR*16-1:16], 0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_cleared", stat4, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
